// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter: the FSM state
// encoding, the data width of one character, and the clock-cycles-per-bit
// helper.
// Optional build macro: UART_RX_PARITY_EN. When it is defined, the receiver
// uses the PARITY state. The state is always declared so that both builds
// share one encoding.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_t;

  // Number of whole clock cycles per bit. The integer division truncates,
  // so the line is sampled slightly early on every bit when the clock is
  // not an exact multiple of the baud rate.
  function automatic int ticks_per_bit(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Bundles the serial line and the byte-level outputs of the UART receiver.
//   Rx_i          serial line, idle high, asynchronous to the clock
//   Data_o        last correctly received byte
//   Done_o        one-cycle pulse when Data_o is updated
//   Busy_o        high while a frame is in progress
//   FrameError_o  one-cycle pulse when the stop bit samples 0
//   ParityError_o one-cycle pulse on a parity mismatch
//                 (present only with UART_RX_PARITY_EN)
// Modports:
//   slave  - the receiver itself
//   master - the line driver / byte consumer side
// Optional build macro: UART_RX_PARITY_EN.
// ---------------------------------------------------------------------------
interface uart_rx_if;

  logic       Rx_i;
  logic [7:0] Data_o;
  logic       Done_o;
  logic       Busy_o;
  logic       FrameError_o;
`ifdef UART_RX_PARITY_EN
  logic       ParityError_o;
`endif

`ifdef UART_RX_PARITY_EN
  modport slave  (input Rx_i, output Data_o, Done_o, Busy_o, FrameError_o, ParityError_o);
  modport master (output Rx_i, input Data_o, Done_o, Busy_o, FrameError_o, ParityError_o);
`else
  modport slave  (input Rx_i, output Data_o, Done_o, Busy_o, FrameError_o);
  modport master (output Rx_i, input Data_o, Done_o, Busy_o, FrameError_o);
`endif

endinterface

// File: rtl/uart_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_rx_bit_timer
// Down-counter that paces bit sampling. Strobe is high while the count is
// zero. On the next clock the count reloads to TICKS-1, so strobes are one
// bit period apart.
//   Clock     system clock, rising edge
//   Reset     asynchronous, active-low
//   Load      reload to TICKS-1 (used to park the timer while idle)
//   HalfLoad  reload to TICKS/2-1 (first strobe lands mid start bit);
//             takes priority over Load
//   Strobe    sample strobe
// ---------------------------------------------------------------------------
module uart_rx_bit_timer #(
  parameter int TICKS = 10
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Load,
  input  logic HalfLoad,
  output logic Strobe
);

  localparam int            CW   = $clog2(TICKS);
  localparam logic [CW-1:0] FULL = CW'(TICKS - 1);
  localparam logic [CW-1:0] HALF = CW'(TICKS / 2 - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_count;

  // Count down. Reload on an explicit request or when the count reaches zero.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count <= FULL;
    end else if (HalfLoad) begin
      r_count <= HALF;
    end else if (Load) begin
      r_count <= FULL;
    end else if (r_count == '0) begin
      r_count <= FULL;
    end else begin
      r_count <= r_count - ONE;
    end
  end

  assign Strobe = (r_count == '0);

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Asynchronous serial receiver with 8N1 framing (8 data bits, LSB first,
// 1 stop bit). The receiver synchronises the line, qualifies the start bit
// at mid-bit, samples each bit at mid-period, and presents the received
// byte with a one-cycle Done_o strobe.
// Parameters:
//   CLOCK_HZ  system clock frequency in Hz
//   BAUD      line bit rate; CLOCK_HZ/BAUD must be at least 4
// Ports:
//   Clock     system clock, rising edge
//   Reset     asynchronous, active-low
//   bus       uart_rx_if.slave (Rx_i in; Data_o, Done_o, Busy_o,
//             FrameError_o and optionally ParityError_o out)
// Optional build macro: UART_RX_PARITY_EN selects 8E1 framing, where a
// parity bit follows the data bits and parity is even.
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ = 1_000_000,
  parameter int BAUD     = 100_000
) (
  input logic      Clock,
  input logic      Reset,
  uart_rx_if.slave bus
);

  localparam int TICKS = ticks_per_bit(CLOCK_HZ, BAUD);
  localparam int IW    = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  generate
    if (TICKS < 4) begin : g_ticksCheck
      $error("uart_rx: CLOCK_HZ/BAUD must be at least 4");
    end
  endgenerate

  logic r_rxMeta, r_rxSync, r_rxPrev;
  logic w_startEdge, w_strobe, w_timerLoad, w_timerHalfLoad, w_parityOk;

  uart_state_t          r_state;
  logic [IW-1:0]        r_bitIndex;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done, r_frameError, r_busy;
`ifdef UART_RX_PARITY_EN
  logic                 r_parityBit, r_parityError;
`endif

  // Two-flop synchroniser, plus a third flop that remembers the previous
  // synchronised level. The flops reset to the idle-high line level, so
  // reset release never looks like a start edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxMeta <= bus.Rx_i;
      r_rxSync <= r_rxMeta;
      r_rxPrev <= r_rxSync;
    end
  end

  assign w_startEdge = r_rxPrev & ~r_rxSync;

  // The timer is held at full reload while idle, so it produces no strobes
  // there. A start edge half-loads it, which places every later strobe at
  // mid-bit.
  assign w_timerHalfLoad = (r_state == IDLE) && w_startEdge;
  assign w_timerLoad     = (r_state == IDLE) && !w_startEdge;

  uart_rx_bit_timer #(
    .TICKS(TICKS)
  ) u_bitTimer (
    .Clock   (Clock),
    .Reset   (Reset),
    .Load    (w_timerLoad),
    .HalfLoad(w_timerHalfLoad),
    .Strobe  (w_strobe)
  );

`ifdef UART_RX_PARITY_EN
  assign w_parityOk = ((^r_shift) == r_parityBit);
`else
  assign w_parityOk = 1'b1;
`endif

  // Frame FSM with registered outputs. Pulses default low each cycle.
  // After a frame ends, the FSM leaves STOP at mid-stop-bit, so a start edge
  // at the end of the stop bit is already seen in IDLE.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state       <= IDLE;
      r_bitIndex    <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_done        <= 1'b0;
      r_frameError  <= 1'b0;
      r_busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityBit   <= 1'b0;
      r_parityError <= 1'b0;
`endif
    end else begin
      r_done        <= 1'b0;
      r_frameError  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityError <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_startEdge) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          // A line that is high again at mid start bit was a glitch.
          if (w_strobe) begin
            if (!r_rxSync) begin
              r_state    <= DATA;
              r_bitIndex <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (w_strobe) begin
            r_shift[r_bitIndex] <= r_rxSync;
            if (r_bitIndex == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bitIndex <= r_bitIndex + IDX_ONE;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_strobe) begin
            r_parityBit <= r_rxSync;
            r_state     <= STOP;
          end
        end
`endif
        STOP: begin
          // Data_o changes only for a fully good frame. Both error pulses
          // may fire together, but never together with Done_o.
          if (w_strobe) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (r_rxSync && w_parityOk) begin
              r_data <= r_shift;
              r_done <= 1'b1;
            end
            if (!r_rxSync) begin
              r_frameError <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (!w_parityOk) begin
              r_parityError <= 1'b1;
            end
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Data_o        = r_data;
  assign bus.Done_o        = r_done;
  assign bus.Busy_o        = r_busy;
  assign bus.FrameError_o  = r_frameError;
`ifdef UART_RX_PARITY_EN
  assign bus.ParityError_o = r_parityError;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at CLOCK_HZ=1_000_000 and BAUD=100_000,
// which gives 10 clock cycles per bit. The bench serialises frames onto Rx_i.
// A reference model derives the expected received bytes and error pulses
// from the byte value, the stop bit and the parity bit of each frame.
// A monitor collects what the DUT reports.
// Optional build macro: UART_RX_PARITY_EN (frames carry an even-parity bit).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLOCK_HZ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int TICKS    = CLOCK_HZ / BAUD;

  logic clock = 1'b0;
  logic reset = 1'b0;

  uart_rx_if bus();

  uart_rx #(
    .CLOCK_HZ(CLOCK_HZ),
    .BAUD    (BAUD)
  ) dut (
    .Clock(clock),
    .Reset(reset),
    .bus  (bus.slave)
  );

  // 1 MHz system clock.
  always #500 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model state: the expected byte stream and pulse counts.
  logic [7:0] expQ[$];
  logic [7:0] gotQ[$];
  logic [7:0] lastGood = 8'h00;
  int expDone = 0, expFerr = 0, expPerr = 0;

  // Monitor: records DUT pulses, sampled on the falling edge.
  int   doneCount = 0, ferrCount = 0, perrCount = 0;
  int   overlapCount = 0, longDoneCount = 0;
  logic prevDone = 1'b0;

  always @(negedge clock) begin
    if (bus.Done_o === 1'b1) begin
      doneCount++;
      gotQ.push_back(bus.Data_o);
    end
    if (bus.FrameError_o === 1'b1) ferrCount++;
    if (bus.Done_o === 1'b1 && bus.FrameError_o === 1'b1) overlapCount++;
    if (bus.Done_o === 1'b1 && prevDone) longDoneCount++;
    prevDone = (bus.Done_o === 1'b1);
`ifdef UART_RX_PARITY_EN
    if (bus.ParityError_o === 1'b1) perrCount++;
`endif
  end

  // Hold one bit level on the line for one bit period.
  task automatic driveBit(input logic b);
    bus.Rx_i = b;
    repeat (TICKS) @(negedge clock);
  endtask

  // Send one frame and update the model. parityFlip inverts the correct
  // even-parity bit; it has no effect without parity framing.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input logic parityFlip, input int gap);
    logic parityOk;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
    driveBit((^data) ^ parityFlip);
    parityOk = !parityFlip;
`else
    parityOk = 1'b1;
`endif
    driveBit(stopBit);
    if (stopBit && parityOk) begin
      expQ.push_back(data);
      lastGood = data;
      expDone++;
    end
    if (!stopBit) expFerr++;
    if (!parityOk) expPerr++;
    bus.Rx_i = 1'b1;
    repeat (gap) @(negedge clock);
  endtask

  // Let the last frame finish, then compare everything the model predicts.
  task automatic compareSection(input string tag);
    int n;
    repeat (2 * TICKS) @(negedge clock);
    checkOutput({tag, ".count"}, gotQ.size(), expQ.size());
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) checkOutput({tag, ".byte"}, gotQ[i], expQ[i]);
    checkOutput({tag, ".done"}, doneCount, expDone);
    checkOutput({tag, ".ferr"}, ferrCount, expFerr);
    checkOutput({tag, ".perr"}, perrCount, expPerr);
    checkOutput({tag, ".data"}, bus.Data_o, lastGood);
    checkOutput({tag, ".busy"}, bus.Busy_o, 1'b0);
    gotQ.delete();
    expQ.delete();
  endtask

  initial begin
    logic [7:0] hello[5];
    logic [7:0] rb;
    logic       rs, rp;
    int         rg;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    // Reset values, sampled while reset is held.
    bus.Rx_i = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("rst.data", bus.Data_o, 8'h00);
    checkOutput("rst.done", bus.Done_o, 1'b0);
    checkOutput("rst.busy", bus.Busy_o, 1'b0);
    checkOutput("rst.ferr", bus.FrameError_o, 1'b0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // A single character.
    applyStimulus(8'h48, 1'b1, 1'b0, 0);
    compareSection("single");

    // "Hello" back-to-back, with no idle time between frames.
    foreach (hello[i]) applyStimulus(hello[i], 1'b1, 1'b0, 0);
    compareSection("hello");

    // A short low glitch is rejected at mid start bit.
    bus.Rx_i = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("glitch.busyHigh", bus.Busy_o, 1'b1);
    bus.Rx_i = 1'b1;
    repeat (TICKS / 2 + 4 - 3) @(negedge clock);
    checkOutput("glitch.busyLow", bus.Busy_o, 1'b0);
    compareSection("glitch");

    // A bad stop bit, then a good frame.
    applyStimulus(8'h55, 1'b0, 1'b0, TICKS);
    applyStimulus(8'hA5, 1'b1, 1'b0, 0);
    compareSection("framing");

    // Reset in the middle of data bit 4 aborts the frame.
    bus.Rx_i = 1'b0;
    repeat (TICKS) @(negedge clock);
    for (int i = 0; i < 4; i++) driveBit(1'b0);
    bus.Rx_i = 1'b1;
    repeat (TICKS / 2) @(negedge clock);
    checkOutput("midrst.busyBefore", bus.Busy_o, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("midrst.busy", bus.Busy_o, 1'b0);
    checkOutput("midrst.data", bus.Data_o, 8'h00);
    lastGood = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3 * TICKS) @(negedge clock);
    applyStimulus(8'h3C, 1'b1, 1'b0, 0);
    compareSection("midrst");

`ifdef UART_RX_PARITY_EN
    // The parity bit is correct for 0x07 only when it is 1.
    applyStimulus(8'h07, 1'b1, 1'b0, 0);
    applyStimulus(8'h07, 1'b1, 1'b1, 0);
    applyStimulus(8'h07, 1'b0, 1'b1, TICKS);
    compareSection("parity");
`endif

    // Random frames with occasional stop and parity errors. The line must
    // rise again after a bad stop bit before the next start edge counts.
    for (int k = 0; k < 24; k++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 5) != 0);
      rp = ($urandom_range(0, 4) == 0);
      rg = rs ? $urandom_range(0, 3) : TICKS;
      applyStimulus(rb, rs, rp, rg);
    end
    compareSection("random");

    checkOutput("doneVsFerrOverlap", overlapCount, 0);
    checkOutput("donePulseWidth", longDoneCount, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
